// File: rtl/ahb_write_ctrl.sv
// ahb_write_ctrl: AHB-Lite write master for the edge-detection output path.
// Packs pixel bytes little-endian into 32-bit words and writes them as single
// NONSEQ transfers to curr_addr. A trailing partial word goes out as byte writes.
// Optional feature: define AHB_WR_ERROR_EN to abort a frame on HRESP=1 in a data phase.
module ahb_write_ctrl (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [15:0] length,
    input  logic [15:0] width,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] curr_addr,
    output logic        addr_update_enable_w,
    output logic        plus4_r,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StWaddr,
        StWdata,
        StBaddr,
        StBdata,
        StDone
    } state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    state_e      state_q;
    logic [31:0] total_q;
    logic [31:0] pix_cnt_q;
    logic [2:0]  byte_cnt_q;
    logic [1:0]  tail_q;
    logic [31:0] word_q;

    logic        accept;
    logic [2:0]  byte_cnt_nxt;
    logic [31:0] pix_cnt_nxt;
    logic [7:0]  tail_byte;
    logic        resp_err;

`ifdef AHB_WR_ERROR_EN
    logic err_q;
    assign err      = err_q;
    assign resp_err = HREADY && HRESP;
`else
    logic unused_hresp;
    assign unused_hresp = HRESP;
    assign err          = 1'b0;
    assign resp_err     = 1'b0;
`endif

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign tail_byte = word_q[{tail_q, 3'b000} +: 8];

    // Moore decode of bus and stream outputs from the registered state.
    always_comb begin
        pix_ready            = 1'b0;
        addr_update_enable_w = 1'b0;
        plus4_r              = 1'b0;
        HADDR                = 32'd0;
        HTRANS               = HtransIdle;
        HWRITE               = 1'b0;
        HSIZE                = 3'b000;
        HWDATA               = 32'd0;
        unique case (state_q)
            StFill: begin
                pix_ready = (byte_cnt_q < 3'd4) && (pix_cnt_q < total_q);
            end
            StWaddr: begin
                HTRANS               = HtransNonseq;
                HWRITE               = 1'b1;
                HSIZE                = 3'b010;
                HADDR                = curr_addr;
                addr_update_enable_w = HREADY;
                plus4_r              = 1'b1;
            end
            StWdata: begin
                HWDATA = word_q;
            end
            StBaddr: begin
                HTRANS               = HtransNonseq;
                HWRITE               = 1'b1;
                HSIZE                = 3'b000;
                HADDR                = curr_addr;
                addr_update_enable_w = HREADY;
            end
            StBdata: begin
                HWDATA = {4{tail_byte}};
            end
            default: ;
        endcase
    end

    // Counter look-ahead so FILL can leave in the same cycle the last byte lands.
    always_comb begin
        accept       = pix_valid && pix_ready;
        byte_cnt_nxt = byte_cnt_q + {2'b00, accept};
        pix_cnt_nxt  = pix_cnt_q + {31'd0, accept};
    end

    // Frame sequencer: packing, word writes, tail byte writes, completion.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            total_q    <= 32'd0;
            pix_cnt_q  <= 32'd0;
            byte_cnt_q <= 3'd0;
            tail_q     <= 2'd0;
            word_q     <= 32'd0;
`ifdef AHB_WR_ERROR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Total is registered here and tested in FILL, which keeps the
                        // multiplier off the next-state path; an empty frame exits from FILL.
                        total_q    <= 32'(length) * 32'(width);
                        pix_cnt_q  <= 32'd0;
                        byte_cnt_q <= 3'd0;
                        tail_q     <= 2'd0;
`ifdef AHB_WR_ERROR_EN
                        err_q      <= 1'b0;
`endif
                        state_q    <= StFill;
                    end
                end
                StFill: begin
                    if (accept) begin
                        word_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= pix_data;
                    end
                    byte_cnt_q <= byte_cnt_nxt;
                    pix_cnt_q  <= pix_cnt_nxt;
                    if (byte_cnt_nxt == 3'd4) begin
                        state_q <= StWaddr;
                    end else if (pix_cnt_nxt == total_q) begin
                        if (byte_cnt_nxt == 3'd0) begin
                            state_q <= StDone;
                        end else begin
                            tail_q  <= 2'd0;
                            state_q <= StBaddr;
                        end
                    end
                end
                StWaddr: begin
                    if (HREADY) begin
                        state_q <= StWdata;
                    end
                end
                StWdata: begin
                    if (resp_err) begin
`ifdef AHB_WR_ERROR_EN
                        err_q   <= 1'b1;
`endif
                        state_q <= StDone;
                    end else if (HREADY) begin
                        byte_cnt_q <= 3'd0;
                        state_q    <= (pix_cnt_q == total_q) ? StDone : StFill;
                    end
                end
                StBaddr: begin
                    if (HREADY) begin
                        state_q <= StBdata;
                    end
                end
                StBdata: begin
                    if (resp_err) begin
`ifdef AHB_WR_ERROR_EN
                        err_q   <= 1'b1;
`endif
                        state_q <= StDone;
                    end else if (HREADY) begin
                        tail_q <= tail_q + 2'd1;
                        if (({1'b0, tail_q} + 3'd1) == byte_cnt_q) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StBaddr;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_write_ctrl.sv
// tb_ahb_write_ctrl: randomized frame writes checked against a transaction-list
// model of the expected AHB writes, plus directed timing, stall, reset and error cases.
module tb_ahb_write_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [15:0] length;
    logic [15:0] width;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] curr_addr;
    logic        addr_update_enable_w;
    logic        plus4_r;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  pix_mem[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [2:0]  exp_size[$];

    always #5 HCLK = ~HCLK;

    ahb_write_ctrl dut (
        .HCLK                 (HCLK),
        .HRESETn              (HRESETn),
        .start                (start),
        .length               (length),
        .width                (width),
        .pix_data             (pix_data),
        .pix_valid            (pix_valid),
        .pix_ready            (pix_ready),
        .curr_addr            (curr_addr),
        .addr_update_enable_w (addr_update_enable_w),
        .plus4_r              (plus4_r),
        .HADDR                (HADDR),
        .HTRANS               (HTRANS),
        .HWRITE               (HWRITE),
        .HSIZE                (HSIZE),
        .HWDATA               (HWDATA),
        .HREADY               (HREADY),
        .HRESP                (HRESP),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected write list: full words at base+4k, then the tail as byte writes.
    task automatic build_model(input int unsigned total, input logic [31:0] base);
        int unsigned words;
        logic [7:0]  b;
        words = total / 4;
        for (int k = 0; k < int'(words); k++) begin
            exp_addr.push_back(base + 32'(4 * k));
            exp_size.push_back(3'd2);
            exp_data.push_back({pix_mem[4*k+3], pix_mem[4*k+2], pix_mem[4*k+1], pix_mem[4*k]});
        end
        for (int j = 0; j < int'(total % 4); j++) begin
            b = pix_mem[4*words+j];
            exp_addr.push_back(base + 32'(4 * words) + 32'(j));
            exp_size.push_back(3'd0);
            exp_data.push_back({4{b}});
        end
    endtask

    task automatic run_frame(input int unsigned l, input int unsigned w, input logic [31:0] base,
                             input int unsigned vpct, input int unsigned rpct, input int exp_cyc,
                             input bit pat, input int unsigned hold_n, input bit resp_err,
                             input bit poke);
        int unsigned total, pix_idx, xfers, hold_cnt, n_exp, budget;
        bit          in_data, resp_done, done_seen, upd, p4;
        logic [31:0] cur_data;
        int          cyc;
        total = l * w;
        length = 16'(l);
        width  = 16'(w);
        pix_mem.delete();
        for (int i = 0; i < int'(total); i++) begin
            pix_mem.push_back(pat ? 8'((i + 1) * 17) : 8'($urandom));
        end
        exp_addr.delete();
        exp_data.delete();
        exp_size.delete();
        build_model(total, base);
        n_exp = exp_addr.size();
        curr_addr = base;
        pix_idx = 0; xfers = 0; hold_cnt = 0; in_data = 0; resp_done = 0; done_seen = 0;
        upd = 0; p4 = 0; cur_data = 0;
        budget = total * 40 + 60;
        @(posedge HCLK); #1;
        start = 1'b1; pix_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc <= int'(budget)) begin
            if (upd) curr_addr = curr_addr + (p4 ? 32'd4 : 32'd1);
            upd = 0;
            if (poke) begin
                start = (cyc == 3);
                if (cyc == 3) begin
                    length = 16'd0;
                    width  = 16'd0;
                end
            end
            pix_valid = (pix_idx < total) && ($urandom_range(99) < vpct);
            if (pix_idx < total) pix_data = pix_mem[pix_idx];
            else pix_data = 8'($urandom);
            HRESP = 1'b0;
            if (in_data && resp_err && !resp_done) begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end else if (in_data && hold_cnt < hold_n) begin
                HREADY = 1'b0;
            end else begin
                HREADY = ($urandom_range(99) < rpct);
            end
            if (in_data) hold_cnt++;
            @(negedge HCLK);
            upd = addr_update_enable_w;
            p4  = plus4_r;
            if (done) begin
                done_seen = 1;
                if (exp_cyc >= 0) check("done_cycle", cyc, exp_cyc);
            end else begin
                check("busy", busy, 1);
            end
            if (in_data) begin
                check("data_htrans", HTRANS, 2'b00);
                check("hwdata", HWDATA, cur_data);
                check("upd_in_data", addr_update_enable_w, 0);
                check("ready_in_data", pix_ready, 0);
                if (HREADY) begin
                    in_data = 0;
                    if (HRESP) resp_done = 1;
                end
            end else if (HTRANS == 2'b10) begin
                if (exp_addr.size() == 0) begin
                    check("extra_xfer", HTRANS, 2'b00);
                end else begin
                    check("haddr", HADDR, exp_addr[0]);
                    check("hsize", HSIZE, exp_size[0]);
                    check("hwrite", HWRITE, 1);
                    check("upd_pulse", addr_update_enable_w, HREADY);
                    check("ready_in_addr", pix_ready, 0);
                    if (HREADY) begin
                        check("plus4", plus4_r, exp_size[0] == 3'd2);
                        cur_data = exp_data[0];
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                        void'(exp_size.pop_front());
                        in_data = 1;
                        hold_cnt = 0;
                        xfers++;
                    end
                end
            end else begin
                check("idle_htrans", HTRANS, 2'b00);
                check("upd_idle", addr_update_enable_w, 0);
            end
            if (pix_valid && pix_ready) pix_idx++;
            if (!done_seen) begin
                @(posedge HCLK); #1;
                cyc++;
            end
        end
        if (!done_seen) check("done_timeout", done, 1);
        start = 1'b0; pix_valid = 1'b0; HRESP = 1'b0; HREADY = 1'b1;
`ifdef AHB_WR_ERROR_EN
        if (resp_err) begin
            check("err_set", err, 1);
            check("xfers_on_err", xfers, 1);
            check("pix_on_err", pix_idx, 4);
        end else begin
            check("xfers", xfers, n_exp);
            check("err_clear", err, 0);
            check("pix_accepted", pix_idx, total);
        end
`else
        check("xfers", xfers, n_exp);
        check("err_clear", err, 0);
        check("pix_accepted", pix_idx, total);
`endif
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
`ifdef AHB_WR_ERROR_EN
        if (resp_err) check("err_sticky", err, 1);
`endif
    endtask

    initial begin
        bit found;
        HRESETn = 1'b0; start = 1'b0; length = 16'd0; width = 16'd0;
        pix_data = 8'd0; pix_valid = 1'b0; curr_addr = 32'd0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_upd", addr_update_enable_w, 0);
        HRESETn = 1'b1;

        // l, w, base, vpct, rpct, exp_cyc, pat, hold_n, resp_err, poke
        run_frame(2, 2, 32'h0000_1000, 100, 100, 7, 1, 0, 0, 0);
        run_frame(1, 6, 32'h0000_2000, 100, 100, 13, 1, 0, 0, 0);
        run_frame(0, 5, 32'h0000_2400, 100, 100, 2, 1, 0, 0, 0);
        run_frame(2, 2, 32'h0000_2800, 100, 100, 10, 1, 3, 0, 0);

        // Reset while parked in the word address phase.
        length = 16'd2; width = 16'd2; curr_addr = 32'h0000_3000;
        HREADY = 1'b0; pix_valid = 1'b1; pix_data = 8'hEE;
        @(posedge HCLK); #1; start = 1'b1;
        @(posedge HCLK); #1; start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge HCLK);
            if (HTRANS == 2'b10) found = 1;
        end
        check("rst_reach_waddr", HTRANS, 2'b10);
        HRESETn = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        check("mid_rst_htrans", HTRANS, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", pix_ready, 0);
        check("mid_rst_hwdata", HWDATA, 32'd0);
        HRESETn = 1'b1; pix_valid = 1'b0; HREADY = 1'b1;
        run_frame(2, 2, 32'h0000_3000, 100, 100, 7, 0, 0, 0, 0);

        // HRESP on the first data phase.
        run_frame(2, 4, 32'h0000_4000, 100, 100, -1, 1, 0, 1, 0);

        for (int n = 0; n < 10; n++) begin
            run_frame($urandom_range(4, 1), $urandom_range(7, 1), $urandom & 32'hFFFF_FFFC,
                      $urandom_range(100, 60), $urandom_range(100, 50), -1, 0, 0, 0, n == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
